// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants for the fetch queue stage
package fetch_pkg;
    localparam int          DEF_WORD_SIZE = 32;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_STEP   = 32'd4;
    // sll $0,$0,0 - what decode sees on an empty head
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush and occupancy count
module fetch_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // a push at full is accepted only when the head leaves in the same cycle
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;
endmodule

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - instruction fetch with request/response memory port and decode queue
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int                   WORD_SIZE = DEF_WORD_SIZE,
    parameter int                   DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(DEF_RESET_PC),
    parameter logic [WORD_SIZE-1:0] PC_STEP   = WORD_SIZE'(DEF_PC_STEP),
    localparam int                  CW        = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_taken,
    input  logic [WORD_SIZE-1:0] br_base,
    input  logic [WORD_SIZE-1:0] br_offset,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_pc,
    output logic [WORD_SIZE-1:0] out_instruction,
    output logic [CW-1:0]        occupancy
);
    logic [WORD_SIZE-1:0]   r_pc;
    logic [CW-1:0]          r_inflight;
    logic [CW-1:0]          r_discard;
    logic [CW-1:0]          w_tag_count;
    logic [WORD_SIZE-1:0]   w_tag_pc;
    logic [2*WORD_SIZE-1:0] w_head;
    logic [WORD_SIZE-1:0]   w_target;
    logic                   w_has_room;
    logic                   w_issue;
    logic                   w_accept_rsp;
    logic                   w_drop_rsp;
    logic                   w_pop;

    // queued plus outstanding words are capped so a response always has a slot
    assign w_has_room   = ({1'b0, occupancy} + {1'b0, r_inflight}) < (CW+1)'(DEPTH);
    assign imem_req     = !rst && !br_taken && w_has_room;
    assign imem_addr    = r_pc;
    assign w_issue      = imem_req && imem_gnt;
    assign w_accept_rsp = imem_rvalid && !br_taken && (r_discard == '0);
    assign w_drop_rsp   = imem_rvalid && (r_discard != '0);
    assign w_pop        = out_valid && out_ready;
    assign w_target     = br_base + (br_offset << 2);

    fetch_fifo #(.WIDTH(WORD_SIZE), .DEPTH(DEPTH)) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (br_taken),
        .i_push      (w_issue),
        .i_push_data (r_pc),
        .i_pop       (w_accept_rsp),
        .o_head_data (w_tag_pc),
        .o_count     (w_tag_count)
    );

    fetch_fifo #(.WIDTH(2*WORD_SIZE), .DEPTH(DEPTH)) u_instr_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (br_taken),
        .i_push      (w_accept_rsp),
        .i_push_data ({w_tag_pc, imem_rdata}),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_count     (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_issue) - CW'(imem_rvalid);
            if (br_taken) begin
                // words already requested belong to the old path
                r_pc      <= w_target;
                r_discard <= r_inflight - CW'(imem_rvalid);
            end else begin
                if (w_issue)    r_pc      <= r_pc + PC_STEP;
                if (w_drop_rsp) r_discard <= r_discard - CW'(1);
            end
        end
    end

    assign out_valid       = (occupancy != '0);
    assign out_pc          = out_valid ? w_head[2*WORD_SIZE-1:WORD_SIZE] : '0;
    assign out_instruction = out_valid ? w_head[WORD_SIZE-1:0] : WORD_SIZE'(NOP_INSTR);

    a_rsp_has_slot: assert property (@(posedge clk) disable iff (rst)
        (imem_rvalid && !br_taken && (r_discard == '0)) |-> (occupancy != CW'(DEPTH)));
    a_rsp_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (r_inflight != '0));
    a_tags_bounded: assert property (@(posedge clk) disable iff (rst)
        w_tag_count <= r_inflight);
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - directed bench for fetch_queue_stage with a simple in-order memory
module tb_fetch_queue_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_taken = 1'b0;
    logic [31:0] br_base = '0;
    logic [31:0] br_offset = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [2:0]  occupancy;

    logic        gnt_en = 1'b0;
    logic        rsp_en = 1'b0;
    logic [31:0] pending[$];
    logic [31:0] issue_log[$];
    int          grant_count = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    fetch_queue_stage dut (
        .clk             (clk),
        .rst             (rst),
        .br_taken        (br_taken),
        .br_base         (br_base),
        .br_offset       (br_offset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .occupancy       (occupancy)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    // one clock: memory decides grant/response, edge, then bookkeeping
    task automatic cycle();
        logic        rsp;
        logic        iss;
        logic [31:0] iaddr;
        #1;
        rsp         = rsp_en && !rst && (pending.size() > 0);
        imem_rvalid = rsp;
        imem_rdata  = rsp ? instr_of(pending[0]) : 32'h0;
        imem_gnt    = gnt_en && !rst;
        #1;
        iss   = imem_req && imem_gnt;
        iaddr = imem_addr;
        @(posedge clk);
        if (rst) begin
            pending.delete();
        end else begin
            if (rsp) void'(pending.pop_front());
            if (iss) begin
                pending.push_back(iaddr);
                issue_log.push_back(iaddr);
                grant_count++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        br_taken = 1'b0;
        cycle();
        rst = 1'b0;
        grant_count = 0;
        issue_log.delete();
    endtask

    task automatic wait_first_out(input string name, input logic [31:0] exp_pc);
        logic        found = 1'b0;
        logic [31:0] got_pc = '0;
        logic [31:0] got_ins = '0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            if (out_valid) begin
                found = 1'b1;
                got_pc = out_pc;
                got_ins = out_instruction;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL %s_timeout got no out_valid want pc %h", name, exp_pc);
        end else begin
            vectors++;
            if (got_pc !== exp_pc) begin
                miscompares++;
                $display("FAIL %s_pc got %h want %h", name, got_pc, exp_pc);
            end
            vectors++;
            if (got_ins !== instr_of(exp_pc)) begin
                miscompares++;
                $display("FAIL %s_instr got %h want %h", name, got_ins, instr_of(exp_pc));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", imem_req); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vectors++; if (occupancy !== 3'd0) begin miscompares++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
        vectors++; if (out_instruction !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", out_instruction); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1;
        cycle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_early_valid got %b want 0", out_valid); end
        for (int j = 1; j <= 8; j++) begin
            cycle();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %b want 1", j, out_valid); end
            vectors++; if (out_pc !== 32'(4 * (j - 1))) begin miscompares++; $display("FAIL stream_pc[%0d] got %h want %h", j, out_pc, 32'(4 * (j - 1))); end
            vectors++; if (out_instruction !== instr_of(32'(4 * (j - 1)))) begin miscompares++; $display("FAIL stream_instr[%0d] got %h want %h", j, out_instruction, instr_of(32'(4 * (j - 1)))); end
            vectors++; if (occupancy !== 3'd1) begin miscompares++; $display("FAIL stream_occ[%0d] got %0d want 1", j, occupancy); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; gnt_en = 1'b1; rsp_en = 1'b1;
        repeat (8) cycle();
        vectors++; if (grant_count != 4) begin miscompares++; $display("FAIL bp_grants got %0d want 4", grant_count); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req got %b want 0", imem_req); end
        vectors++; if (occupancy !== 3'd4) begin miscompares++; $display("FAIL bp_occ got %0d want 4", occupancy); end
        vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head got %h want 0", out_pc); end
        vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL bp_addr got %h want 10", imem_addr); end
        out_ready = 1'b1;
        issue_log.delete();
        for (int j = 0; j < 8; j++) begin
            cycle();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_drain_valid[%0d] got %b want 1", j, out_valid); end
            vectors++; if (out_pc !== 32'(4 * (j + 1))) begin miscompares++; $display("FAIL bp_drain_pc[%0d] got %h want %h", j, out_pc, 32'(4 * (j + 1))); end
        end
        vectors++;
        if (issue_log.size() == 0) begin
            miscompares++; $display("FAIL bp_resume got no grant want addr 10");
        end else if (issue_log[0] !== 32'h10) begin
            miscompares++; $display("FAIL bp_resume got %h want 10", issue_log[0]);
        end
    endtask

    task automatic test_branch();
        do_reset();
        out_ready = 1'b1; gnt_en = 1'b1; rsp_en = 1'b0;
        cycle();
        cycle();
        vectors++; if (occupancy !== 3'd0) begin miscompares++; $display("FAIL br_pre_occ got %0d want 0", occupancy); end
        br_taken = 1'b1; br_base = 32'h40; br_offset = 32'd3;
        cycle();
        br_taken = 1'b0;
        vectors++; if (imem_addr !== 32'h4C) begin miscompares++; $display("FAIL br_addr got %h want 4c", imem_addr); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL br_valid got %b want 0", out_valid); end
        rsp_en = 1'b1;
        wait_first_out("br", 32'h4C);
    endtask

    task automatic test_branch_rvalid();
        do_reset();
        out_ready = 1'b1; gnt_en = 1'b1; rsp_en = 1'b0;
        repeat (3) cycle();
        br_taken = 1'b1; br_base = 32'h100; br_offset = 32'd0; rsp_en = 1'b1;
        cycle();
        br_taken = 1'b0;
        vectors++; if (occupancy !== 3'd0) begin miscompares++; $display("FAIL brrv_occ got %0d want 0", occupancy); end
        wait_first_out("brrv", 32'h100);
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1; gnt_en = 1'b1; rsp_en = 1'b0;
        cycle();
        cycle();
        br_taken = 1'b1; br_base = 32'h200; br_offset = 32'd0;
        cycle();
        br_base = 32'h300; rsp_en = 1'b1;
        cycle();
        br_taken = 1'b0;
        vectors++; if (imem_addr !== 32'h300) begin miscompares++; $display("FAIL b2b_addr got %h want 300", imem_addr); end
        wait_first_out("b2b", 32'h300);
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1; gnt_en = 1'b0; rsp_en = 1'b1;
        br_taken = 1'b1; br_base = 32'hFFFF_FFF0; br_offset = 32'd3;
        cycle();
        br_taken = 1'b0;
        vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_target got %h want fffffffc", imem_addr); end
        gnt_en = 1'b1;
        cycle();
        gnt_en = 1'b0;
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next got %h want 0", imem_addr); end
        br_taken = 1'b1; br_base = 32'h10; br_offset = 32'hFFFF_FFFF;
        cycle();
        br_taken = 1'b0;
        vectors++; if (imem_addr !== 32'h0C) begin miscompares++; $display("FAIL wrap_neg_off got %h want c", imem_addr); end
        gnt_en = 1'b1;
        wait_first_out("wrap", 32'h0C);
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0; gnt_en = 1'b1; rsp_en = 1'b1;
        repeat (6) cycle();
        vectors++; if (occupancy !== 3'd4) begin miscompares++; $display("FAIL rmid_full got %0d want 4", occupancy); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        vectors++; if (occupancy !== 3'd0) begin miscompares++; $display("FAIL rmid_occ got %0d want 0", occupancy); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rmid_addr got %h want 0", imem_addr); end
        out_ready = 1'b1;
        wait_first_out("rmid", 32'h0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_branch_rvalid();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
